// File: rtl/exc_int_unit_pkg.sv
// Shared definitions for the exception/interrupt unit: ISA exception codes,
// control-op encodings, control-register indices, STATUS bit positions,
// CAUSE field layout and a helper that packs a CAUSE value.
package exc_int_unit_pkg;

    // Exception codes carried down the pipeline with each instruction
    localparam int ISA_EXP_W = 3;
    localparam logic [ISA_EXP_W-1:0] ISA_EXP_NO_EXP = 3'd0;
    localparam logic [ISA_EXP_W-1:0] EXP_EXT_INT    = 3'd1;
    localparam logic [ISA_EXP_W-1:0] EXP_UNDEF_INSN = 3'd2;
    localparam logic [ISA_EXP_W-1:0] EXP_OVERFLOW   = 3'd3;
    localparam logic [ISA_EXP_W-1:0] EXP_MISS_ALIGN = 3'd4;
    localparam logic [ISA_EXP_W-1:0] EXP_TRAP       = 3'd5;

    // Control operations decoded in ID and committed in MEM
    localparam int CTRL_OP_W = 2;
    typedef enum logic [CTRL_OP_W-1:0] {
        CTRL_OP_NOP  = 2'd0,
        CTRL_OP_EXRT = 2'd1,
        CTRL_OP_WRCR = 2'd2
    } ctrl_op_e;

    // Control-register indices
    localparam int CREG_ADDR_W = 5;
    localparam logic [CREG_ADDR_W-1:0] CREG_STATUS   = 5'd0;
    localparam logic [CREG_ADDR_W-1:0] CREG_NEST_LVL = 5'd1;
    localparam logic [CREG_ADDR_W-1:0] CREG_EPC      = 5'd2;
    localparam logic [CREG_ADDR_W-1:0] CREG_VEC_BASE = 5'd3;
    localparam logic [CREG_ADDR_W-1:0] CREG_CAUSE    = 5'd4;
    localparam logic [CREG_ADDR_W-1:0] CREG_INT_MASK = 5'd5;
    localparam logic [CREG_ADDR_W-1:0] CREG_IRQ_PEND = 5'd6;
    localparam logic [CREG_ADDR_W-1:0] CREG_IRQ_MODE = 5'd7;

    // STATUS bit positions
    localparam int ST_MODE = 0;
    localparam int ST_IE   = 1;
    localparam int ST_OVF  = 2;
    localparam int ST_UNF  = 3;

    localparam logic MODE_KERNEL = 1'b0;

    // CAUSE layout: code in the low bits, delay-slot flag, channel in [12:8]
    localparam int CAUSE_W       = 13;
    localparam int CAUSE_DLY_BIT = 7;
    localparam int CAUSE_CH_LSB  = 8;
    localparam int CAUSE_CH_W    = 5;

    function automatic logic [CAUSE_W-1:0] make_cause(
        input logic [ISA_EXP_W-1:0]  code,
        input logic [CAUSE_CH_W-1:0] ch
    );
        logic [CAUSE_W-1:0] c;
        c = '0;
        c[ISA_EXP_W-1:0]               = code;
        c[CAUSE_DLY_BIT]               = 1'b0;
        c[CAUSE_CH_LSB +: CAUSE_CH_W]  = ch;
        return c;
    endfunction

endpackage

// File: rtl/exc_int_unit_irq.sv
// Interrupt pending capture (edge/level per channel) plus lowest-index encoder.
// Latency: edge capture lands one clk after the 0->1 transition; level is combinational.
// Backpressure: none; edges are captured every cycle, stalls only gate the clears.
// Ports: irq/mode/mask in, W1C and take clears in, pend/any/ch out.
module irq_pend_enc
    import exc_int_unit_pkg::*;
#(
    parameter int IRQ_CH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IRQ_CH-1:0]     irq,
    input  logic [IRQ_CH-1:0]     mode,
    input  logic [IRQ_CH-1:0]     mask,
    input  logic                  w1c_en,
    input  logic [IRQ_CH-1:0]     w1c_dat,
    input  logic                  take_en,
    input  logic [CAUSE_CH_W-1:0] take_ch,
    output logic [IRQ_CH-1:0]     pend,
    output logic                  any,
    output logic [CAUSE_CH_W-1:0] ch
);

    logic [IRQ_CH-1:0] irq_q;
    logic [IRQ_CH-1:0] edge_q;
    logic [IRQ_CH-1:0] edge_set;
    logic [IRQ_CH-1:0] clr;
    logic [IRQ_CH-1:0] active;

    assign edge_set = irq & ~irq_q;

    always_comb begin
        clr = w1c_en ? w1c_dat : '0;
        for (int i = 0; i < IRQ_CH; i++) begin
            if (take_en && (take_ch == CAUSE_CH_W'(i))) begin
                clr[i] = 1'b1;
            end
        end
    end

    // Set beats clear; bits of level channels are held at 0 so a later
    // switch to edge mode never exposes a stale capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q  <= '0;
            edge_q <= '0;
        end else begin
            irq_q  <= irq;
            edge_q <= mode & (edge_set | (edge_q & ~clr));
        end
    end

    assign pend   = (mode & edge_q) | (~mode & irq);
    assign active = pend & ~mask;
    assign any    = |active;

    always_comb begin
        ch = '0;
        for (int i = IRQ_CH - 1; i >= 0; i--) begin
            if (active[i]) begin
                ch = CAUSE_CH_W'(i);
            end
        end
    end

endmodule

// File: rtl/exc_int_unit.sv
// CPU control unit: exceptions, vectored interrupts, nested save stack, control registers.
// Latency: flush/new_pc combinational in the commit cycle; state lands on the next clk.
// Backpressure: stall freezes all state and suppresses flush (edge capture continues).
// Ports: MEM-stage commit inputs, irq lines, creg read port, exe_mode/int_detect/flush/new_pc out.
module exc_int_unit
    import exc_int_unit_pkg::*;
#(
    parameter  int IRQ_CH     = 8,
    parameter  int NEST_DEPTH = 4,
    parameter  int ADDR_W     = 30,
    parameter  int VEC_SHIFT  = 2,
    localparam int DATA_W     = ADDR_W + 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [IRQ_CH-1:0]      irq,
    input  logic                   stall,
    input  logic                   mem_en,
    input  logic [ADDR_W-1:0]      mem_pc,
    input  logic [ISA_EXP_W-1:0]   mem_exp_code,
    input  logic [CTRL_OP_W-1:0]   mem_ctrl_op,
    input  logic [4:0]             mem_dst_addr,
    input  logic [DATA_W-1:0]      mem_out,
    input  logic [4:0]             creg_rd_addr,
    output logic [DATA_W-1:0]      creg_rd_data,
    output logic                   exe_mode,
    output logic                   int_detect,
    output logic                   flush,
    output logic [ADDR_W-1:0]      new_pc
);

    localparam int IDX_W = $clog2(NEST_DEPTH);
    localparam int LVL_W = IDX_W + 1;

    logic                  int_en, ovf, unf;
    logic [LVL_W-1:0]      nest_lvl;
    logic [ADDR_W-1:0]     vec_base;
    logic [CAUSE_W-1:0]    cause;
    logic [IRQ_CH-1:0]     mask, mode, pend;
    logic                  irq_any;
    logic [CAUSE_CH_W-1:0] irq_ch;

    logic [ADDR_W-1:0]     stk_epc  [NEST_DEPTH];
    logic                  stk_mode [NEST_DEPTH];
    logic                  stk_ie   [NEST_DEPTH];

    logic                  full, empty, commit;
    logic                  do_exp, do_int, do_exrt, do_wrcr;
    logic [IDX_W-1:0]      top_idx, push_idx;
    logic [ADDR_W-1:0]     top_epc, int_vec;
    logic                  unused_mem_out_hi;

    assign unused_mem_out_hi = ^mem_out[DATA_W-1:ADDR_W];

    assign full     = (nest_lvl == LVL_W'(NEST_DEPTH));
    assign empty    = (nest_lvl == '0);
    assign top_idx  = IDX_W'(nest_lvl - LVL_W'(1));
    // A push on a full stack overwrites the top entry rather than wrapping.
    assign push_idx = full ? top_idx : IDX_W'(nest_lvl);
    assign top_epc  = empty ? '0 : stk_epc[top_idx];
    assign int_vec  = vec_base + ((ADDR_W'(irq_ch) + ADDR_W'(1)) << VEC_SHIFT);

    // Interrupts are refused once the stack is full so that only a
    // synchronous exception can ever overflow it.
    assign int_detect = int_en & ~full & irq_any;

    assign commit  = mem_en & ~stall & ~reset;
    assign do_exp  = commit & (mem_exp_code != ISA_EXP_NO_EXP);
    assign do_int  = commit & ~do_exp & int_detect;
    assign do_exrt = commit & ~do_exp & ~int_detect & (mem_ctrl_op == CTRL_OP_EXRT);
    assign do_wrcr = commit & ~do_exp & ~int_detect & (mem_ctrl_op == CTRL_OP_WRCR);

    irq_pend_enc #(.IRQ_CH(IRQ_CH)) u_irq (
        .clk     (clk),
        .reset   (reset),
        .irq     (irq),
        .mode    (mode),
        .mask    (mask),
        .w1c_en  (do_wrcr && (mem_dst_addr == CREG_IRQ_PEND)),
        .w1c_dat (mem_out[IRQ_CH-1:0]),
        .take_en (do_int),
        .take_ch (irq_ch),
        .pend    (pend),
        .any     (irq_any),
        .ch      (irq_ch)
    );

    always_comb begin
        flush  = 1'b0;
        new_pc = '0;
        if (do_exp) begin
            flush  = 1'b1;
            new_pc = vec_base;
        end else if (do_int) begin
            flush  = 1'b1;
            new_pc = int_vec;
        end else if (do_exrt) begin
            flush  = 1'b1;
            new_pc = top_epc;
        end else if (do_wrcr) begin
            flush  = 1'b1;
            new_pc = mem_pc + ADDR_W'(1);
        end
    end

    // Stack contents need no reset: nest_lvl alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_exp || do_int) begin
            stk_epc[push_idx]  <= mem_pc;
            stk_mode[push_idx] <= exe_mode;
            stk_ie[push_idx]   <= int_en;
        end else if (do_wrcr && (mem_dst_addr == CREG_EPC) && !empty) begin
            stk_epc[top_idx] <= mem_out[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exe_mode <= MODE_KERNEL;
            int_en   <= 1'b0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            nest_lvl <= '0;
            vec_base <= '0;
            cause    <= '0;
            mask     <= '1;
            mode     <= '0;
        end else begin
            if (do_exp || do_int) begin
                exe_mode <= MODE_KERNEL;
                int_en   <= 1'b0;
                cause    <= do_exp ? make_cause(mem_exp_code, '0)
                                   : make_cause(EXP_EXT_INT, irq_ch);
                if (full) ovf      <= 1'b1;
                else      nest_lvl <= nest_lvl + LVL_W'(1);
            end
            if (do_exrt) begin
                if (empty) begin
                    unf <= 1'b1;
                end else begin
                    exe_mode <= stk_mode[top_idx];
                    int_en   <= stk_ie[top_idx];
                    nest_lvl <= nest_lvl - LVL_W'(1);
                end
            end
            if (do_wrcr) begin
                case (mem_dst_addr)
                    CREG_STATUS: begin
                        exe_mode <= mem_out[ST_MODE];
                        int_en   <= mem_out[ST_IE];
                        ovf      <= 1'b0;
                        unf      <= 1'b0;
                    end
                    CREG_VEC_BASE: vec_base <= mem_out[ADDR_W-1:0];
                    CREG_CAUSE:    cause    <= mem_out[CAUSE_W-1:0];
                    CREG_INT_MASK: mask     <= mem_out[IRQ_CH-1:0];
                    CREG_IRQ_MODE: mode     <= mem_out[IRQ_CH-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        creg_rd_data = '0;
        case (creg_rd_addr)
            CREG_STATUS: begin
                creg_rd_data[ST_MODE] = exe_mode;
                creg_rd_data[ST_IE]   = int_en;
                creg_rd_data[ST_OVF]  = ovf;
                creg_rd_data[ST_UNF]  = unf;
            end
            CREG_NEST_LVL: creg_rd_data = DATA_W'(nest_lvl);
            CREG_EPC:      creg_rd_data = DATA_W'(top_epc);
            CREG_VEC_BASE: creg_rd_data = DATA_W'(vec_base);
            CREG_CAUSE:    creg_rd_data = DATA_W'(cause);
            CREG_INT_MASK: creg_rd_data = DATA_W'(mask);
            CREG_IRQ_PEND: creg_rd_data = DATA_W'(pend);
            CREG_IRQ_MODE: creg_rd_data = DATA_W'(mode);
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exc_int_unit.sv
// Directed bench for exc_int_unit: reset values, vectored dispatch, edge
// pending, nesting overflow/LIFO return, underflow, stall vs. commit priority.
module tb_exc_int_unit;
    import exc_int_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  irq;
    logic        stall;
    logic        mem_en;
    logic [29:0] mem_pc;
    logic [2:0]  mem_exp_code;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic [31:0] mem_out;
    logic [4:0]  creg_rd_addr;
    logic [31:0] creg_rd_data;
    logic        exe_mode;
    logic        int_detect;
    logic        flush;
    logic [29:0] new_pc;

    int total = 0;
    int bad   = 0;

    exc_int_unit dut (
        .clk          (clk),
        .reset        (reset),
        .irq          (irq),
        .stall        (stall),
        .mem_en       (mem_en),
        .mem_pc       (mem_pc),
        .mem_exp_code (mem_exp_code),
        .mem_ctrl_op  (mem_ctrl_op),
        .mem_dst_addr (mem_dst_addr),
        .mem_out      (mem_out),
        .creg_rd_addr (creg_rd_addr),
        .creg_rd_data (creg_rd_data),
        .exe_mode     (exe_mode),
        .int_detect   (int_detect),
        .flush        (flush),
        .new_pc       (new_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_en       = 1'b0;
        stall        = 1'b0;
        mem_pc       = '0;
        mem_exp_code = ISA_EXP_NO_EXP;
        mem_ctrl_op  = CTRL_OP_NOP;
        mem_dst_addr = '0;
        mem_out      = '0;
    endtask

    task automatic do_reset();
        idle();
        irq          = '0;
        creg_rd_addr = '0;
        reset        = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        creg_rd_addr = a;
        #1;
        d = creg_rd_data;
    endtask

    // One MEM-stage commit; flush/new_pc are sampled at the falling edge.
    task automatic commit(input logic [29:0] pc, input logic [2:0] code,
                          input logic [1:0] op, input logic [4:0] dst,
                          input logic [31:0] dat,
                          output logic fl, output logic [29:0] npc);
        @(posedge clk);
        #1;
        mem_en       = 1'b1;
        mem_pc       = pc;
        mem_exp_code = code;
        mem_ctrl_op  = op;
        mem_dst_addr = dst;
        mem_out      = dat;
        @(negedge clk);
        fl  = flush;
        npc = new_pc;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wrcr(input logic [4:0] dst, input logic [31:0] dat);
        logic        fl;
        logic [29:0] npc;
        commit(30'h10, ISA_EXP_NO_EXP, CTRL_OP_WRCR, dst, dat, fl, npc);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        fl;
        logic [29:0] npc;
        do_reset();
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", flush); end
        total++; if (new_pc !== 30'h0) begin bad++; $display("FAIL reset_new_pc got=%h exp=0", new_pc); end
        total++; if (int_detect !== 1'b0) begin bad++; $display("FAIL reset_int_detect got=%b exp=0", int_detect); end
        rd(CREG_STATUS, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=0", d); end
        rd(CREG_INT_MASK, d);
        total++; if (d !== 32'hFF) begin bad++; $display("FAIL reset_mask got=%h exp=ff", d); end
        rd(CREG_NEST_LVL, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_nest got=%h exp=0", d); end
        rd(CREG_IRQ_MODE, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_mode got=%h exp=0", d); end
        rd(CREG_CAUSE, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_cause got=%h exp=0", d); end
        // Unmapped index: write ignored, still reads 0, STATUS untouched
        commit(30'h20, ISA_EXP_NO_EXP, CTRL_OP_WRCR, 5'd12, 32'hFFFF_FFFF, fl, npc);
        total++; if (fl !== 1'b1 || npc !== 30'h21) begin bad++; $display("FAIL unmapped_wrcr_redirect got=%b/%h exp=1/21", fl, npc); end
        rd(5'd12, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%h exp=0", d); end
        rd(CREG_STATUS, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_status got=%h exp=0", d); end
    endtask

    task automatic test_vectored_irq();
        logic [31:0] d;
        logic        fl;
        logic [29:0] npc;
        do_reset();
        commit(30'h10, ISA_EXP_NO_EXP, CTRL_OP_WRCR, CREG_VEC_BASE, 32'h100, fl, npc);
        total++; if (fl !== 1'b1 || npc !== 30'h11) begin bad++; $display("FAIL wrcr_redirect got=%b/%h exp=1/11", fl, npc); end
        wrcr(CREG_INT_MASK, 32'hF0);
        wrcr(CREG_STATUS, 32'h3);
        irq = 8'h0A;
        #1;
        total++; if (int_detect !== 1'b1) begin bad++; $display("FAIL vec_int_detect got=%b exp=1", int_detect); end
        commit(30'h40, ISA_EXP_NO_EXP, CTRL_OP_NOP, 5'd0, 32'h0, fl, npc);
        total++; if (fl !== 1'b1 || npc !== 30'h108) begin bad++; $display("FAIL vec_take got=%b/%h exp=1/108", fl, npc); end
        rd(CREG_EPC, d);
        total++; if (d !== 32'h40) begin bad++; $display("FAIL vec_epc got=%h exp=40", d); end
        rd(CREG_STATUS, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL vec_status got=%h exp=0", d); end
        rd(CREG_CAUSE, d);
        total++; if (d !== 32'h101) begin bad++; $display("FAIL vec_cause got=%h exp=101", d); end
        rd(CREG_NEST_LVL, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL vec_nest got=%h exp=1", d); end
        total++; if (int_detect !== 1'b0) begin bad++; $display("FAIL vec_detect_after got=%b exp=0", int_detect); end
        irq = 8'h00;
        commit(30'h200, ISA_EXP_NO_EXP, CTRL_OP_EXRT, 5'd0, 32'h0, fl, npc);
        total++; if (fl !== 1'b1 || npc !== 30'h40) begin bad++; $display("FAIL vec_exrt got=%b/%h exp=1/40", fl, npc); end
        rd(CREG_STATUS, d);
        total++; if (d !== 32'h3) begin bad++; $display("FAIL vec_restore got=%h exp=3", d); end
    endtask

    task automatic test_edge_pending();
        logic [31:0] d;
        logic        fl;
        logic [29:0] npc;
        do_reset();
        wrcr(CREG_IRQ_MODE, 32'h04);
        @(posedge clk); #1; irq = 8'h04;
        @(posedge clk); #1; irq = 8'h00;
        rd(CREG_IRQ_PEND, d);
        total++; if (d !== 32'h04) begin bad++; $display("FAIL edge_captured got=%h exp=04", d); end
        tick(); tick(); tick();
        rd(CREG_IRQ_PEND, d);
        total++; if (d !== 32'h04) begin bad++; $display("FAIL edge_persist got=%h exp=04", d); end
        total++; if (int_detect !== 1'b0) begin bad++; $display("FAIL edge_masked_detect got=%b exp=0", int_detect); end
        wrcr(CREG_INT_MASK, 32'hFB);
        wrcr(CREG_STATUS, 32'h2);
        total++; if (int_detect !== 1'b1) begin bad++; $display("FAIL edge_detect got=%b exp=1", int_detect); end
        commit(30'h80, ISA_EXP_NO_EXP, CTRL_OP_NOP, 5'd0, 32'h0, fl, npc);
        total++; if (fl !== 1'b1 || npc !== 30'hC) begin bad++; $display("FAIL edge_take got=%b/%h exp=1/c", fl, npc); end
        rd(CREG_IRQ_PEND, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL edge_cleared got=%h exp=0", d); end
        rd(CREG_CAUSE, d);
        total++; if (d !== 32'h201) begin bad++; $display("FAIL edge_cause got=%h exp=201", d); end
        @(posedge clk); #1; irq = 8'h04;
        @(posedge clk); #1; irq = 8'h00;
        rd(CREG_IRQ_PEND, d);
        total++; if (d !== 32'h04) begin bad++; $display("FAIL w1c_before got=%h exp=04", d); end
        wrcr(CREG_IRQ_PEND, 32'h04);
        rd(CREG_IRQ_PEND, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL w1c_after got=%h exp=0", d); end
    endtask

    task automatic test_nesting();
        logic [31:0] d;
        logic        fl;
        logic [29:0] npc;
        logic [29:0] ret_pc [4];
        ret_pc[0] = 30'h50; ret_pc[1] = 30'h30; ret_pc[2] = 30'h20; ret_pc[3] = 30'h10;
        do_reset();
        wrcr(CREG_VEC_BASE, 32'h300);
        wrcr(CREG_STATUS, 32'h1);
        for (int k = 0; k < 4; k++) begin
            commit(30'(16 * (k + 1)), EXP_TRAP, CTRL_OP_NOP, 5'd0, 32'h0, fl, npc);
            total++; if (fl !== 1'b1 || npc !== 30'h300) begin bad++; $display("FAIL nest_push%0d got=%b/%h exp=1/300", k, fl, npc); end
        end
        rd(CREG_NEST_LVL, d);
        total++; if (d !== 32'h4) begin bad++; $display("FAIL nest_lvl4 got=%h exp=4", d); end
        rd(CREG_STATUS, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL nest_status4 got=%h exp=0", d); end
        commit(30'h50, EXP_TRAP, CTRL_OP_NOP, 5'd0, 32'h0, fl, npc);
        rd(CREG_NEST_LVL, d);
        total++; if (d !== 32'h4) begin bad++; $display("FAIL ovf_lvl got=%h exp=4", d); end
        rd(CREG_STATUS, d);
        total++; if (d !== 32'h4) begin bad++; $display("FAIL ovf_status got=%h exp=4", d); end
        rd(CREG_EPC, d);
        total++; if (d !== 32'h50) begin bad++; $display("FAIL ovf_epc got=%h exp=50", d); end
        rd(CREG_CAUSE, d);
        total++; if (d !== 32'h5) begin bad++; $display("FAIL ovf_cause got=%h exp=5", d); end
        total++; if (int_detect !== 1'b0) begin bad++; $display("FAIL ovf_detect got=%b exp=0", int_detect); end
        for (int k = 0; k < 4; k++) begin
            commit(30'h3F0, ISA_EXP_NO_EXP, CTRL_OP_EXRT, 5'd0, 32'h0, fl, npc);
            total++; if (fl !== 1'b1 || npc !== ret_pc[k]) begin bad++; $display("FAIL lifo%0d got=%b/%h exp=1/%h", k, fl, npc, ret_pc[k]); end
        end
        rd(CREG_NEST_LVL, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL pop_lvl got=%h exp=0", d); end
        rd(CREG_STATUS, d);
        total++; if (d !== 32'h5) begin bad++; $display("FAIL pop_status got=%h exp=5", d); end
        wrcr(CREG_STATUS, 32'h1);
        rd(CREG_STATUS, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL ovf_clear got=%h exp=1", d); end
    endtask

    task automatic test_underflow();
        logic [31:0] d;
        logic        fl;
        logic [29:0] npc;
        do_reset();
        wrcr(CREG_STATUS, 32'h1);
        commit(30'h60, ISA_EXP_NO_EXP, CTRL_OP_EXRT, 5'd0, 32'h0, fl, npc);
        total++; if (fl !== 1'b1 || npc !== 30'h0) begin bad++; $display("FAIL unf_redirect got=%b/%h exp=1/0", fl, npc); end
        rd(CREG_STATUS, d);
        total++; if (d !== 32'h9) begin bad++; $display("FAIL unf_status got=%h exp=9", d); end
        total++; if (exe_mode !== 1'b1) begin bad++; $display("FAIL unf_mode got=%b exp=1", exe_mode); end
        rd(CREG_NEST_LVL, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL unf_lvl got=%h exp=0", d); end
        wrcr(CREG_STATUS, 32'h1);
        rd(CREG_STATUS, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL unf_clear got=%h exp=1", d); end
    endtask

    task automatic test_stall_priority();
        logic [31:0] d;
        do_reset();
        wrcr(CREG_VEC_BASE, 32'h400);
        wrcr(CREG_IRQ_MODE, 32'h01);
        wrcr(CREG_INT_MASK, 32'hFE);
        wrcr(CREG_STATUS, 32'h2);
        @(posedge clk); #1;
        mem_en = 1'b1; mem_pc = 30'h70; mem_exp_code = EXP_UNDEF_INSN;
        stall = 1'b1; irq = 8'h01;
        @(negedge clk);
        total++; if (flush !== 1'b0 || new_pc !== 30'h0) begin bad++; $display("FAIL stall_flush got=%b/%h exp=0/0", flush, new_pc); end
        total++; if (int_detect !== 1'b0) begin bad++; $display("FAIL stall_detect_early got=%b exp=0", int_detect); end
        @(posedge clk); #1;
        irq = 8'h00; stall = 1'b0;
        rd(CREG_NEST_LVL, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL stall_frozen got=%h exp=0", d); end
        total++; if (int_detect !== 1'b1) begin bad++; $display("FAIL stall_edge_captured got=%b exp=1", int_detect); end
        @(negedge clk);
        total++; if (flush !== 1'b1 || new_pc !== 30'h400) begin bad++; $display("FAIL exp_wins got=%b/%h exp=1/400", flush, new_pc); end
        @(posedge clk); #1;
        idle();
        rd(CREG_IRQ_PEND, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL irq_still_pending got=%h exp=1", d); end
        rd(CREG_CAUSE, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL exp_cause got=%h exp=2", d); end
        rd(CREG_EPC, d);
        total++; if (d !== 32'h70) begin bad++; $display("FAIL exp_epc got=%h exp=70", d); end
        total++; if (int_detect !== 1'b0) begin bad++; $display("FAIL exp_detect_off got=%b exp=0", int_detect); end
    endtask

    // Reset while the handler from the previous test is still active
    task automatic test_reset_mid();
        logic [31:0] d;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(CREG_NEST_LVL, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_nest got=%h exp=0", d); end
        rd(CREG_IRQ_PEND, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_pend got=%h exp=0", d); end
        rd(CREG_INT_MASK, d);
        total++; if (d !== 32'hFF) begin bad++; $display("FAIL mid_mask got=%h exp=ff", d); end
        rd(CREG_VEC_BASE, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_vec got=%h exp=0", d); end
        rd(CREG_IRQ_MODE, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_mode got=%h exp=0", d); end
    endtask

    initial begin
        test_reset();
        test_vectored_irq();
        test_edge_pending();
        test_nesting();
        test_underflow();
        test_stall_priority();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
